// File: rtl/rtmq_stack_arbiter_if.sv
// Requester-side bundle of the RTMQ stack arbiter: request handshake plus pop response.
interface rtmq_stack_arbiter_if #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned W_REG = 32
);
    logic [N_REQ-1:0]       req_vld;
    logic [N_REQ-1:0]       req_op;
    logic [N_REQ*W_REG-1:0] req_dat;
    logic [N_REQ-1:0]       req_rdy;
    logic [N_REQ-1:0]       rsp_vld;
    logic [W_REG-1:0]       rsp_dat;

    modport master (
        output req_vld, req_op, req_dat,
        input  req_rdy, rsp_vld, rsp_dat
    );

    modport slave (
        input  req_vld, req_op, req_dat,
        output req_rdy, rsp_vld, rsp_dat
    );
endinterface

// File: rtl/rtmq_stack_arbiter.sv
// Round-robin push/pop arbiter with occupancy tracking for one RTMQ hardware stack.
// Define RTMQ_STK_GUARD_EN to block overflowing pushes / underflowing pops and flag them.
module rtmq_stack_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned W_REG = 32,
    parameter int unsigned N_DPT = 10,
    parameter int unsigned W_CNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rtmq_stack_arbiter_if.slave  bus,
    output logic                 stk_psh,
    output logic                 stk_pop,
    output logic [W_REG-1:0]     stk_din,
    input  logic [W_REG-1:0]     stk_top,
    output logic [W_CNT-1:0]     cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 err_ovf,
    output logic                 err_unf,
    input  logic                 err_clr
);
    localparam int unsigned W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [W_IDX-1:0] ptr_q, gnt_idx, cand;
    logic [N_REQ-1:0] gnt;
    logic             gnt_any;
    logic             push_hs, pop_hs, do_psh, do_pop, ovf_evt, unf_evt;
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             psh_q, pop_q, pend_q, zero_q;
    logic [W_REG-1:0] din_q, rsp_dat_q;
    logic [W_IDX-1:0] own_q;
    logic [N_REQ-1:0] rsp_vld_q;

    // First valid requester strictly after the last granted one.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr_q;
        gnt_any = 1'b0;
        cand    = ptr_q;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = W_IDX'((32'(ptr_q) + k) % N_REQ);
            if (!gnt_any && bus.req_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign push_hs = gnt_any & bus.req_op[gnt_idx];
    assign pop_hs  = gnt_any & ~bus.req_op[gnt_idx];

`ifdef RTMQ_STK_GUARD_EN
    assign ovf_evt = push_hs & full_q;
    assign unf_evt = pop_hs & empty_q;
`else
    assign ovf_evt = 1'b0;
    assign unf_evt = 1'b0;
`endif

    assign do_psh = push_hs & ~ovf_evt;
    assign do_pop = pop_hs & ~unf_evt;

    // Unguarded requests still strobe the stack, but the count saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (do_psh && !full_q) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !empty_q) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= W_IDX'(N_REQ - 1);
            cnt_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            psh_q     <= 1'b0;
            pop_q     <= 1'b0;
            din_q     <= '0;
            pend_q    <= 1'b0;
            zero_q    <= 1'b0;
            own_q     <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
        end else begin
            if (gnt_any) ptr_q <= gnt_idx;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == W_CNT'(N_DPT));
            empty_q <= (cnt_d == '0);
            psh_q   <= do_psh;
            pop_q   <= do_pop;
            if (do_psh) din_q <= bus.req_dat[32'(gnt_idx) * W_REG +: W_REG];
            pend_q  <= pop_hs;
            zero_q  <= unf_evt;
            if (pop_hs) own_q <= gnt_idx;
            // stk_top is sampled during the strobe cycle, before the stack shifts.
            rsp_vld_q <= '0;
            if (pend_q) begin
                rsp_vld_q[own_q] <= 1'b1;
                rsp_dat_q        <= zero_q ? '0 : stk_top;
            end
        end
    end

`ifdef RTMQ_STK_GUARD_EN
    logic err_ovf_q, err_unf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= ovf_evt | (err_ovf_q & ~err_clr);
            err_unf_q <= unf_evt | (err_unf_q & ~err_clr);
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_ovf        = 1'b0;
    assign err_unf        = 1'b0;
`endif

    assign bus.req_rdy = gnt;
    assign bus.rsp_vld = rsp_vld_q;
    assign bus.rsp_dat = rsp_dat_q;
    assign stk_psh     = psh_q;
    assign stk_pop     = pop_q;
    assign stk_din     = din_q;
    assign cnt         = cnt_q;
    assign full        = full_q;
    assign empty       = empty_q;
endmodule

// File: tb/tb_rtmq_stack_arbiter.sv
// Scoreboard bench for rtmq_stack_arbiter: queue-based LIFO reference model, behavioural stack.
`timescale 1ns/1ps
module tb_rtmq_stack_arbiter;
    localparam int unsigned NR = 3;
    localparam int unsigned WR = 32;
    localparam int unsigned ND = 10;
    localparam int unsigned WC = 4;
`ifdef RTMQ_STK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtmq_stack_arbiter_if #(.N_REQ(NR), .W_REG(WR)) bus ();
    logic          stk_psh, stk_pop, full, empty, err_ovf, err_unf, err_clr;
    logic [WR-1:0] stk_din, stk_top;
    logic [WC-1:0] cnt;

    rtmq_stack_arbiter #(.N_REQ(NR), .W_REG(WR), .N_DPT(ND), .W_CNT(WC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .stk_psh (stk_psh),
        .stk_pop (stk_pop),
        .stk_din (stk_din),
        .stk_top (stk_top),
        .cnt     (cnt),
        .full    (full),
        .empty   (empty),
        .err_ovf (err_ovf),
        .err_unf (err_unf),
        .err_clr (err_clr)
    );

    // Behavioural stack peripheral: no reset of its own, wiped by the bench on reset.
    logic [WR-1:0] mem [ND];
    logic          stk_wipe;
    assign stk_top = mem[0];
    always @(posedge clk) begin
        if (stk_wipe) begin
            for (int i = 0; i < ND; i++) mem[i] <= '0;
        end else if (stk_psh) begin
            for (int i = ND - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= stk_din;
        end else if (stk_pop) begin
            for (int i = 0; i < ND - 1; i++) mem[i] <= mem[i+1];
            mem[ND-1] <= '0;
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct packed {
        int unsigned   own;
        logic [WR-1:0] dat;
        int unsigned   due;
    } rsp_t;

    logic [WR-1:0] ref_stk[$];
    rsp_t          rsp_q[$];
    int unsigned   rr;
    bit            m_ovf, m_unf, exp_psh, exp_pop;
    logic [WR-1:0] exp_din;

    // Reference model: checks registered state, strobes and grant, then applies the handshake.
    always @(negedge clk) begin
        logic [NR-1:0] exp_g;
        int unsigned   gi;
        bit            set_o, set_u;
        logic [WR-1:0] v;
        if (!rst_n) begin
            ref_stk.delete();
            rsp_q.delete();
            rr      = NR - 1;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            exp_psh = 1'b0;
            exp_pop = 1'b0;
        end else begin
            chk("cnt", cnt, ref_stk.size());
            chk("full", full, ref_stk.size() == ND);
            chk("empty", empty, ref_stk.size() == 0);
            chk("err_ovf", err_ovf, m_ovf);
            chk("err_unf", err_unf, m_unf);
            chk("stk_psh", stk_psh, exp_psh);
            if (exp_psh) chk("stk_din", stk_din, exp_din);
            chk("stk_pop", stk_pop, exp_pop);
            exp_g = '0;
            gi    = 0;
            for (int k = 1; k <= NR; k++) begin
                if (exp_g == '0 && bus.req_vld[(rr + k) % NR]) begin
                    gi        = (rr + k) % NR;
                    exp_g[gi] = 1'b1;
                end
            end
            chk("req_rdy", bus.req_rdy, exp_g);
            exp_psh = 1'b0;
            exp_pop = 1'b0;
            set_o   = 1'b0;
            set_u   = 1'b0;
            if (exp_g != '0) begin
                rr = gi;
                if (bus.req_op[gi]) begin
                    v = bus.req_dat[gi*WR +: WR];
                    if (GUARD && ref_stk.size() == ND) begin
                        set_o = 1'b1;
                    end else begin
                        exp_psh = 1'b1;
                        exp_din = v;
                        ref_stk.push_back(v);
                        if (ref_stk.size() > ND) void'(ref_stk.pop_front());
                    end
                end else begin
                    if (ref_stk.size() == 0) begin
                        v       = '0;
                        set_u   = GUARD;
                        exp_pop = !GUARD;
                    end else begin
                        v       = ref_stk.pop_back();
                        exp_pop = 1'b1;
                    end
                    rsp_q.push_back('{own: gi, dat: v, due: cyc + 2});
                end
            end
            if (GUARD) begin
                m_ovf = set_o ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
                m_unf = set_u ? 1'b1 : (err_clr ? 1'b0 : m_unf);
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents pop data.
    always @(negedge clk) begin
        rsp_t r;
        if (rst_n) begin
            if (bus.rsp_vld != '0) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_vld, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_vld", bus.rsp_vld, 64'(1) << r.own);
                    chk("rsp_dat", bus.rsp_dat, r.dat);
                    chk("rsp_latency", cyc, r.due);
                end
            end else if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                chk("rsp_missing", bus.rsp_vld, 64'(1) << rsp_q[0].own);
                void'(rsp_q.pop_front());
            end
        end
    end

    function automatic logic [NR*WR-1:0] put(input int unsigned i, input logic [WR-1:0] val);
        logic [NR*WR-1:0] d;
        d = '0;
        d[i*WR +: WR] = val;
        return d;
    endfunction

    task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] op,
                         input logic [NR*WR-1:0] d, input logic clr);
        @(posedge clk);
        #1;
        bus.req_vld = v;
        bus.req_op  = op;
        bus.req_dat = d;
        err_clr     = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_rdy", bus.req_rdy, 0);
        chk("rst_rsp_vld", bus.rsp_vld, 0);
        chk("rst_rsp_dat", bus.rsp_dat, 0);
        chk("rst_stk_psh", stk_psh, 0);
        chk("rst_stk_pop", stk_pop, 0);
        chk("rst_stk_din", stk_din, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_unf", err_unf, 0);
    endtask

    initial begin
        logic [NR-1:0] v, op;
        int            pp;
        stk_wipe    = 1'b1;
        bus.req_vld = '0;
        bus.req_op  = '0;
        bus.req_dat = '0;
        err_clr     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        stk_wipe = 1'b0;

        drive(3'b001, 3'b001, put(0, 32'hA5A5A5A5), 1'b0);
        idle(3);

        for (int i = 1; i <= 3; i++) drive(3'b001, 3'b001, put(0, WR'(i)), 1'b0);
        for (int i = 0; i < 3; i++) drive(3'b010, 3'b000, '0, 1'b0);
        idle(3);

        // Two requesters pushing together must alternate.
        for (int i = 0; i < 6; i++)
            drive(3'b011, 3'b011, put(0, $urandom) | put(1, $urandom), 1'b0);
        for (int i = 0; i < 7; i++) drive(3'b100, 3'b000, '0, 1'b0);
        idle(3);

        drive(3'b001, 3'b001, put(0, 32'h11), 1'b0);
        drive(3'b010, 3'b000, '0, 1'b0);
        idle(4);

        for (int i = 0; i < 450; i++) begin
            pp = ((i / 50) % 3 == 0) ? 80 : (((i / 50) % 3 == 1) ? 20 : 50);
            for (int r = 0; r < NR; r++) begin
                v[r]  = $urandom_range(0, 99) < 60;
                op[r] = $urandom_range(0, 99) < pp;
            end
            drive(v, op, put(0, $urandom) | put(1, $urandom) | put(2, $urandom),
                  $urandom_range(0, 15) == 0);
        end
        idle(3);

        // Drain, overfill by one, clear, drain, then pop an empty stack.
        for (int i = 0; i < ND + 2; i++) drive(3'b001, 3'b000, '0, 1'b0);
        drive('0, '0, '0, 1'b1);
        for (int i = 0; i < ND + 1; i++) drive(3'b010, 3'b010, put(1, 32'hC000 + i), 1'b0);
        idle(2);
        drive('0, '0, '0, 1'b1);
        idle(2);
        for (int i = 0; i < ND; i++) drive(3'b100, 3'b000, '0, 1'b0);
        drive(3'b001, 3'b000, '0, 1'b0);
        idle(4);

        // Reset while the pop strobe is high: the response must vanish.
        drive(3'b001, 3'b001, put(0, 32'h77), 1'b0);
        drive(3'b001, 3'b000, '0, 1'b0);
        @(posedge clk);
        #1;
        bus.req_vld = '0;
        bus.req_op  = '0;
        #1;
        rst_n    = 1'b0;
        stk_wipe = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        stk_wipe = 1'b0;
        idle(6);
        drive(3'b100, 3'b100, put(2, 32'hBEEF), 1'b0);
        drive(3'b001, 3'b000, '0, 1'b0);
        idle(4);

        chk("rsp_drain", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
